// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the saturating add/subtract datapath.
//   - flag bit positions inside the 3-bit {V, N, Z} flag vector
//   - operation mode encoding (ADD / SUB)
//   - signed MIN/MAX constant builders for an arbitrary width (<= MAX_W)
//   - a generic sum-of-products lookahead carry used both inside a CLA
//     group and across groups
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Widest vector the helper functions handle.
  localparam int MAX_W = 64;

  // Most negative signed value of width w: 1 followed by zeros.
  function automatic logic [MAX_W-1:0] signed_min(input int w);
    logic [MAX_W-1:0] one;
    one = MAX_W'(1);
    return one << (w - 1);
  endfunction

  // Most positive signed value of width w: 0 followed by ones.
  function automatic logic [MAX_W-1:0] signed_max(input int w);
    logic [MAX_W-1:0] one;
    one = MAX_W'(1);
    return (one << (w - 1)) - one;
  endfunction

  // Carry into position n given generate/propagate vectors and a carry-in,
  // written as a flat OR of products so no carry ripples through positions:
  //   c[n] = cin&p[0..n-1] | g[0]&p[1..n-1] | ... | g[n-1]
  function automatic logic lookahead_carry(input logic [MAX_W-1:0] g,
                                           input logic [MAX_W-1:0] p,
                                           input logic             cin,
                                           input int               n);
    logic res;
    logic term;
    res = cin;
    for (int k = 0; k < n; k++) res = res & p[k];
    for (int j = 0; j < n; j++) begin
      term = g[j];
      for (int k = j + 1; k < n; k++) term = term & p[k];
      res = res | term;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_addsub_pipe_if.sv
// ---------------------------------------------------------------------------
// sat_addsub_pipe_if
// Operand/result handshake bundle of the saturating add/subtract pipe.
//   in_valid/in_ready  : operand beat handshake (in_a, in_b, in_mode, in_sat)
//   out_valid/out_ready: result handshake (out_data, out_flags = {V,N,Z})
// Modports:
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : the arithmetic unit
// ---------------------------------------------------------------------------
interface sat_addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_mode;
  logic             in_sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_flags;

  modport master (
    output in_valid, in_a, in_b, in_mode, in_sat, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_sat, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/cla_group.sv
// ---------------------------------------------------------------------------
// cla_group
// GROUP-bit carry-lookahead adder slice.
// Ports:
//   i_a, i_b : operand bits of this group
//   i_cin    : carry into the group
//   o_sum    : group sum
//   o_p      : group propagate (all bits propagate)
//   o_g      : group generate (group produces a carry regardless of i_cin)
// o_p/o_g do not depend on i_cin, so the upper level can combine them
// without forming a loop through the group carry-ins.
// ---------------------------------------------------------------------------
module cla_group
  import alu_pkg::*;
#(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] i_a,
  input  logic [GROUP-1:0] i_b,
  input  logic             i_cin,
  output logic [GROUP-1:0] o_sum,
  output logic             o_p,
  output logic             o_g
);

  logic [GROUP-1:0] w_p;
  logic [GROUP-1:0] w_g;
  logic [MAX_W-1:0] w_p_ext;
  logic [MAX_W-1:0] w_g_ext;
  logic [GROUP-1:0] w_c;

  assign w_p     = i_a ^ i_b;
  assign w_g     = i_a & i_b;
  assign w_p_ext = MAX_W'(w_p);
  assign w_g_ext = MAX_W'(w_g);

  genvar gi;
  generate
    for (gi = 0; gi < GROUP; gi++) begin : g_bit
      assign w_c[gi]   = lookahead_carry(w_g_ext, w_p_ext, i_cin, gi);
      assign o_sum[gi] = w_p[gi] ^ w_c[gi];
    end
  endgenerate

  assign o_p = &w_p;
  assign o_g = lookahead_carry(w_g_ext, w_p_ext, 1'b0, GROUP);

endmodule

// File: rtl/sat_addsub_pipe.sv
// ---------------------------------------------------------------------------
// sat_addsub_pipe
// Two-stage pipelined signed add/subtract with optional saturation.
//   Stage 1: low half sum + half carry-out (CLA groups), registered together
//            with the upper halves of A and effective B and the sat request.
//   Stage 2: upper half from the registered carry, overflow detection,
//            saturation, flags; result held in the output register.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : operand/result handshake bundle (slave side)
//   cnt_clr  : synchronous clear of sat_cnt (wins over an increment)
//   sat_cnt  : number of saturated results delivered, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  sat_addsub_pipe_if.slave  bus,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sat_cnt
);

  localparam int HALF = WIDTH / 2;
  localparam int NG   = HALF / GROUP;
  localparam logic [WIDTH-1:0] L_MIN = WIDTH'(signed_min(WIDTH));
  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(signed_max(WIDTH));

  // ---------------- pipeline registers ----------------
  logic             r_s1_valid;
  logic [HALF-1:0]  r_s1_lo_sum;
  logic             r_s1_carry;
  logic [HALF-1:0]  r_s1_a_hi;
  logic [HALF-1:0]  r_s1_b_hi;
  logic             r_s1_sat;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [2:0]       r_out_flags;
  logic             r_out_sat;
  logic [CNT_W-1:0] r_sat_cnt;

  // ---------------- handshake ----------------
  logic w_out_load;
  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;

  assign w_out_load = !r_out_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_out_load;
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;

  // ---------------- stage 1: low half ----------------
  logic             w_cin;
  logic [WIDTH-1:0] w_b_eff;
  logic [HALF-1:0]  w_lo_sum;
  logic [NG-1:0]    w_lo_gp;
  logic [NG-1:0]    w_lo_gg;
  logic [NG-1:0]    w_lo_cin;
  logic [MAX_W-1:0] w_lo_gp_ext;
  logic [MAX_W-1:0] w_lo_gg_ext;
  logic             w_lo_cout;

  // Subtraction is A + ~B + 1.
  assign w_cin       = (bus.in_mode == MODE_SUB);
  assign w_b_eff     = w_cin ? ~bus.in_b : bus.in_b;
  assign w_lo_gp_ext = MAX_W'(w_lo_gp);
  assign w_lo_gg_ext = MAX_W'(w_lo_gg);
  assign w_lo_cout   = lookahead_carry(w_lo_gg_ext, w_lo_gp_ext, w_cin, NG);

  // ---------------- stage 2: high half ----------------
  logic [HALF-1:0]  w_hi_sum;
  logic [NG-1:0]    w_hi_gp;
  logic [NG-1:0]    w_hi_gg;
  logic [NG-1:0]    w_hi_cin;
  logic [MAX_W-1:0] w_hi_gp_ext;
  logic [MAX_W-1:0] w_hi_gg_ext;

  assign w_hi_gp_ext = MAX_W'(w_hi_gp);
  assign w_hi_gg_ext = MAX_W'(w_hi_gg);

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_lo
      assign w_lo_cin[gi] = lookahead_carry(w_lo_gg_ext, w_lo_gp_ext, w_cin, gi);
      cla_group #(.GROUP(GROUP)) u_cla (
        .i_a   (bus.in_a[gi*GROUP +: GROUP]),
        .i_b   (w_b_eff[gi*GROUP +: GROUP]),
        .i_cin (w_lo_cin[gi]),
        .o_sum (w_lo_sum[gi*GROUP +: GROUP]),
        .o_p   (w_lo_gp[gi]),
        .o_g   (w_lo_gg[gi])
      );
    end
    for (gi = 0; gi < NG; gi++) begin : g_hi
      assign w_hi_cin[gi] = lookahead_carry(w_hi_gg_ext, w_hi_gp_ext, r_s1_carry, gi);
      cla_group #(.GROUP(GROUP)) u_cla (
        .i_a   (r_s1_a_hi[gi*GROUP +: GROUP]),
        .i_b   (r_s1_b_hi[gi*GROUP +: GROUP]),
        .i_cin (w_hi_cin[gi]),
        .o_sum (w_hi_sum[gi*GROUP +: GROUP]),
        .o_p   (w_hi_gp[gi]),
        .o_g   (w_hi_gg[gi])
      );
    end
  endgenerate

  logic [WIDTH-1:0] w_raw;
  logic             w_a_msb;
  logic             w_b_msb;
  logic             w_v;
  logic             w_do_sat;
  logic [WIDTH-1:0] w_res;
  logic [2:0]       w_flags;

  assign w_raw    = {w_hi_sum, r_s1_lo_sum};
  assign w_a_msb  = r_s1_a_hi[HALF-1];
  assign w_b_msb  = r_s1_b_hi[HALF-1];
  // Overflow: like-signed operands producing a result of the other sign.
  assign w_v      = (w_a_msb == w_b_msb) && (w_raw[WIDTH-1] != w_a_msb);
  assign w_do_sat = w_v && r_s1_sat;
  // On overflow the sign of A tells which rail was crossed.
  assign w_res    = w_do_sat ? (w_a_msb ? L_MIN : L_MAX) : w_raw;

  always_comb begin
    w_flags         = 3'b000;
    w_flags[FLAG_V] = w_v;
    w_flags[FLAG_N] = w_res[WIDTH-1];
    w_flags[FLAG_Z] = (w_res == '0);
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_lo_sum <= '0;
      r_s1_carry  <= 1'b0;
      r_s1_a_hi   <= '0;
      r_s1_b_hi   <= '0;
      r_s1_sat    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_flags <= '0;
      r_out_sat   <= 1'b0;
      r_sat_cnt   <= '0;
    end else begin
      if (w_in_fire) begin
        r_s1_lo_sum <= w_lo_sum;
        r_s1_carry  <= w_lo_cout;
        r_s1_a_hi   <= bus.in_a[WIDTH-1:HALF];
        r_s1_b_hi   <= w_b_eff[WIDTH-1:HALF];
        r_s1_sat    <= bus.in_sat;
      end

      // A new beat keeps S1 full even when the old one moves on.
      if (w_in_fire) r_s1_valid <= 1'b1;
      else if (w_out_load) r_s1_valid <= 1'b0;

      if (w_out_load) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data  <= w_res;
          r_out_flags <= w_flags;
          r_out_sat   <= w_do_sat;
        end
      end

      if (cnt_clr) r_sat_cnt <= '0;
      else if (w_out_fire && r_out_sat && !(&r_sat_cnt)) r_sat_cnt <= r_sat_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_flags = r_out_flags;
  assign sat_cnt       = r_sat_cnt;

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_sat_addsub_pipe
// Directed vectors with hand-computed results. The driver pushes the expected
// {data, flags} into a queue when a beat is accepted; a separate monitor pops
// and compares on every output handshake and checks that the output holds
// while stalled. A second instance with CNT_W=2 sees the same stream so the
// counter ceiling can be checked.
// ---------------------------------------------------------------------------
module tb_sat_addsub_pipe;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  logic cnt_clr;
  logic [15:0] sat_cnt;
  logic [1:0]  sat_cnt2;

  always #5 clk = ~clk;

  sat_addsub_pipe_if #(.WIDTH(W)) bus ();
  sat_addsub_pipe_if #(.WIDTH(W)) bus2 ();

  sat_addsub_pipe #(.WIDTH(W), .GROUP(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .cnt_clr(cnt_clr), .sat_cnt(sat_cnt)
  );

  sat_addsub_pipe #(.WIDTH(W), .GROUP(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .cnt_clr(1'b0), .sat_cnt(sat_cnt2)
  );

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_a      = bus.in_a;
  assign bus2.in_b      = bus.in_b;
  assign bus2.in_mode   = bus.in_mode;
  assign bus2.in_sat    = bus.in_sat;
  assign bus2.out_ready = bus.out_ready;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  logic [18:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Vector table: a, b, mode (1=SUB), sat, expected data, expected {V,N,Z}
  logic [15:0] va[19], vb[19], ve[19];
  logic        vm[19], vs[19];
  logic [2:0]  vf[19];

  task automatic setv(input int i, input logic [15:0] a, input logic [15:0] b,
                      input logic m, input logic s, input logic [15:0] e, input logic [2:0] f);
    va[i] = a; vb[i] = b; vm[i] = m; vs[i] = s; ve[i] = e; vf[i] = f;
  endtask

  // ---------------- monitor ----------------
  logic        prev_stall = 1'b0;
  logic [19:0] prev_out   = '0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          chk("stall_hold", {12'd0, bus.out_valid, bus.out_data, bus.out_flags}, {12'd0, prev_out});
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", {13'd0, bus.out_data, bus.out_flags}, 32'hFFFFFFFF);
          end else begin
            logic [18:0] e;
            e = sb.pop_front();
            chk($sformatf("out#%0d", n_out), {13'd0, bus.out_data, bus.out_flags}, {13'd0, e});
            $display("out#%0d data=%h flags=%b", n_out, bus.out_data, bus.out_flags);
            n_out++;
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out   = {bus.out_valid, bus.out_data, bus.out_flags};
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input int i);
    bus.in_valid = 1'b1;
    bus.in_a = va[i]; bus.in_b = vb[i]; bus.in_mode = vm[i]; bus.in_sat = vs[i];
  endtask

  logic saw_not_ready;

  // Streams vectors first..first+n-1 back-to-back, out_ready low for loop
  // cycles stall_lo..stall_hi, and returns once all results are delivered.
  task automatic run_vecs(input int first, input int n, input int stall_lo, input int stall_hi);
    int idx = 0;
    int c = 0;
    saw_not_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (idx == n && sb.size() == 0) begin
        bus.out_ready = 1'b1;
        break;
      end
      if (c > 200) begin
        chk("timeout", 32'(sb.size()), 32'd0);
        sb.delete();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        break;
      end
      bus.out_ready = !(c >= stall_lo && c <= stall_hi);
      if (idx < n) drive(first + idx);
      else bus.in_valid = 1'b0;
      #1;
      if (bus.in_valid && !bus.in_ready) saw_not_ready = 1'b1;
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back({ve[first+idx], vf[first+idx]});
        idx++;
      end
      c++;
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    setv(0,  16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 3'b100);
    setv(1,  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 3'b110);
    setv(2,  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 3'b110);
    setv(3,  16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 3'b001);
    setv(4,  16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0100, 3'b000);
    setv(5,  16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0003, 3'b000);
    setv(6,  16'h0010, 16'h0020, 1'b1, 1'b1, 16'hFFF0, 3'b010);
    setv(7,  16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 3'b110);
    setv(8,  16'h4000, 16'h4000, 1'b0, 1'b1, 16'h7FFF, 3'b100);
    setv(9,  16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 3'b001);
    setv(10, 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 3'b110);
    setv(11, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 16'h7FFF, 3'b100);
    setv(12, 16'h8000, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 3'b110);
    setv(13, 16'h7000, 16'h9000, 1'b1, 1'b1, 16'h7FFF, 3'b100);
    setv(14, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 16'h8000, 3'b110);
    setv(15, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 16'h7FFF, 3'b100);
    setv(16, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 3'b000);
    setv(17, 16'h0002, 16'h0001, 1'b1, 1'b0, 16'h0001, 3'b000);
    setv(18, 16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0008, 3'b000);

    rst = 1'b1; cnt_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_mode = 1'b0; bus.in_sat = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data), 32'd0);
    chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
    chk("rst_sat_cnt",   32'(sat_cnt), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    rst = 1'b0;

    // Overflow / zero / cross-half carry
    run_vecs(0, 1, -1, -1);
    chk("sat_cnt_pos_sat", 32'(sat_cnt), 32'd1);
    chk("sat_cnt2_first", 32'(sat_cnt2), 32'd1);
    run_vecs(1, 1, -1, -1);
    chk("sat_cnt_wrap", 32'(sat_cnt), 32'd1);
    run_vecs(2, 3, -1, -1);
    chk("sat_cnt_neg_sat", 32'(sat_cnt), 32'd2);

    // Backpressure: 6 beats, out_ready low for cycles 3..5
    run_vecs(5, 6, 3, 5);
    chk("bp_in_ready_drop", 32'(saw_not_ready), 32'd1);
    chk("sat_cnt_after_bp", 32'(sat_cnt), 32'd4);
    chk("sat_cnt2_hold", 32'(sat_cnt2), 32'd3);

    // Idle clear
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    chk("cnt_clr_idle", 32'(sat_cnt), 32'd0);

    // Three saturated results
    run_vecs(11, 3, -1, -1);
    chk("sat_cnt_three", 32'(sat_cnt), 32'd3);

    // Fourth saturated result retires together with a clear
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(14);
    #1;
    chk("clr4_in_ready", 32'(bus.in_ready), 32'd1);
    if (bus.in_ready) sb.push_back({ve[14], vf[14]});
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10 && !bus.out_valid; k++) @(negedge clk);
    chk("clr4_out_valid", 32'(bus.out_valid), 32'd1);
    cnt_clr = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("cnt_clr_priority", 32'(sat_cnt), 32'd0);
    chk("sat_cnt2_still", 32'(sat_cnt2), 32'd3);

    // One saturated result so the reset clear is visible
    run_vecs(15, 1, -1, -1);
    chk("sat_cnt_pre_rst", 32'(sat_cnt), 32'd1);

    // Reset with two beats in flight
    bus.out_ready = 1'b0;
    for (int i = 16; i < 18; i++) begin
      drive(i);
      #1;
      if (bus.in_ready) sb.push_back({ve[i], vf[i]});
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    sb.delete();
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_sat_cnt", 32'(sat_cnt), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // First beat after reset: presented now, out_valid after the second edge
    @(negedge clk);
    drive(18);
    #1;
    chk("post_rst_accept", 32'(bus.in_ready), 32'd1);
    if (bus.in_ready) sb.push_back({ve[18], vf[18]});
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("latency_edge1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("latency_edge2", 32'(bus.out_valid), 32'd1);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("out_count", 32'(n_out), 32'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
